hv_unbinder: RTL and testbench
==============================

HV_UNBINDER -- requirements
Module: hv_unbinder

Interface
REQ-001 Parameter HV_DIM, default 1024: hypervector width in bits, at least 2.
REQ-002 Parameter STEP, default 8: maximum rotation in bits per cycle, 1..HV_DIM-1.
REQ-003 Derived SHIFT_W = $clog2(HV_DIM): width of the shift-amount port.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  global enable; when 0, the block holds all state.
REQ-007 in_valid  input  1  a bound hypervector and shift amount are offered.
REQ-008 in_ready  output  1  the block can accept an input; defined as (state==IDLE) && en.
REQ-009 bound_hv  input  HV_DIM  hypervector previously bound by right-rotation.
REQ-010 shift_amt  input  SHIFT_W  rotation amount to undo.
REQ-011 out_valid  output  1  the recovered hypervector is available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 unbound_hv  output  HV_DIM  recovered hypervector: bound_hv rotated left by shift_amt.
REQ-014 err  output  1  one-cycle pulse when an input is rejected.

Function
REQ-015 The block shall have three states: IDLE, ROTATE and DONE.
REQ-016 Acceptance shall occur on a rising edge where in_valid && in_ready; it captures bound_hv into the working register and shift_amt into the remaining counter.
REQ-017 On acceptance with shift_amt >= HV_DIM (possible only when HV_DIM is not a power of two):
- no capture takes place;
- err pulses high for exactly one cycle;
- the state stays IDLE.
REQ-018 On acceptance with shift_amt == 0, the next state shall be DONE; otherwise the next state shall be ROTATE.
REQ-019 In ROTATE with en=1, each edge shall:
- rotate the working register left by r = min(STEP, remaining), so bit i moves to bit (i+r) mod HV_DIM;
- set remaining to remaining - r.
REQ-020 ROTATE shall go to DONE on the edge where remaining becomes 0.
REQ-021 Latency: with N = ceil(shift_amt/STEP), out_valid shall first be high N+1 cycles after the acceptance cycle.
REQ-022 In DONE, out_valid=1 and unbound_hv shall hold stable until a handoff edge.
- A handoff edge is one where out_ready && en.
- On the handoff edge the state returns to IDLE; out_valid and in_ready are never high together.
REQ-023 When en=0, the block shall not change state, counter, working register or err, and shall complete no handshake.
REQ-024 unbound_hv shall be driven from the working register in all states; it is meaningful only while out_valid=1.
REQ-025 For any k < HV_DIM, the block shall be the exact inverse of a k-bit cyclic right rotation, so unbinding a k-bound vector returns the original.

Reset
REQ-026 While rst=1, asynchronously:
- state shall be IDLE and the remaining counter 0;
- the working register shall be all-zero;
- out_valid=0 and err=0.
REQ-027 Reset asserted mid-ROTATE or in DONE shall discard the operation; no out_valid pulse shall follow after rst deasserts.
REQ-028 After rst deasserts, in_ready shall equal en on the first cycle.

Configuration
REQ-029 Macro HV_UNBINDER_SIMILARITY_EN, when defined:
- adds input ref_hv [HV_DIM] and output overlap [$clog2(HV_DIM+1)];
- ref_hv is captured at acceptance;
- overlap = popcount(unbound_hv & captured ref_hv), registered on entry to DONE, valid with out_valid, and reset to 0.
REQ-030 Without HV_UNBINDER_SIMILARITY_EN, ports ref_hv and overlap shall not exist, and no popcount logic shall be built; all other behaviour shall be identical.

Verification
REQ-031 Single-step rotation: HV_DIM=16, STEP=1, bound_hv=16'h0001, shift_amt=3 -> unbound_hv=16'h0008, out_valid 4 cycles after acceptance.
REQ-032 Multi-bit step: HV_DIM=16, STEP=4, bound_hv=16'h8001, shift_amt=9 -> 3 ROTATE cycles, unbound_hv=16'h0300, out_valid 4 cycles after acceptance.
REQ-033 Zero shift with backpressure: shift_amt=0, bound_hv=16'hA5A5, out_ready=0 for 5 cycles -> out_valid 1 cycle after acceptance, held with 16'hA5A5; IDLE on the edge after out_ready=1.
REQ-034 Rejection and stall, HV_DIM=12, STEP=1:
- shift_amt=13 -> err single-cycle pulse, state stays IDLE, no out_valid;
- en=0 for 3 cycles mid-ROTATE -> completion delayed by exactly 3 cycles.
REQ-035 Reset and similarity:
- rst pulsed mid-ROTATE -> out_valid=0 and unbound_hv=0 immediately, no later out_valid;
- with macro, ref_hv=16'h0008 against REQ-031 stimulus -> overlap=1.

Source files
------------

// File: rtl/hv_unbinder.sv
// Hypervector unbinder: recovers a vector that was bound by cyclic right
// rotation by rotating it left by the same amount, STEP bits per cycle.
// Latency: ceil(shift_amt/STEP)+1 cycles from acceptance to out_valid.
// Backpressure: result is held in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              global enable; 0 freezes every register
//   in_valid/in_ready, bound_hv, shift_amt   input handshake and operands
//   out_valid/out_ready, unbound_hv          output handshake and result
//   err             one-cycle pulse when shift_amt >= HV_DIM is rejected
// Optional (macro HV_UNBINDER_SIMILARITY_EN):
//   ref_hv          reference vector captured at acceptance
//   overlap         popcount(unbound_hv & ref), registered on entry to DONE

module hv_unbinder #(
  parameter int HV_DIM = 1024,
  parameter int STEP   = 8,
  localparam int SHIFT_W = $clog2(HV_DIM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [HV_DIM-1:0]  bound_hv,
  input  logic [SHIFT_W-1:0] shift_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [HV_DIM-1:0]  unbound_hv,
  output logic               err
`ifdef HV_UNBINDER_SIMILARITY_EN
  ,
  input  logic [HV_DIM-1:0]              ref_hv,
  output logic [$clog2(HV_DIM+1)-1:0]    overlap
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [SHIFT_W-1:0] STEP_C = SHIFT_W'(STEP);
  localparam logic [SHIFT_W:0]   DIM_C  = (SHIFT_W+1)'(HV_DIM);

  state_t              state_q;
  logic [SHIFT_W-1:0]  rem_q;
  logic [HV_DIM-1:0]   work_q;
  logic                out_valid_q;
  logic                err_q;

  logic [SHIFT_W-1:0]  step_r;
  logic [SHIFT_W:0]    rsh;
  logic [HV_DIM-1:0]   rot_d;
  logic [SHIFT_W-1:0]  rem_d;
  logic                accept;
  logic                shift_bad;

  assign in_ready   = (state_q == IDLE) && en;
  assign out_valid  = out_valid_q;
  assign unbound_hv = work_q;
  assign err        = err_q;

  // Per-cycle rotation amount is min(STEP, remaining). A left rotate by r is
  // (x << r) | (x >> (HV_DIM - r)); with r == 0 the right shift clears fully,
  // so the expression degenerates to x without a special case.
  always_comb begin
    step_r    = (rem_q > STEP_C) ? STEP_C : rem_q;
    rsh       = DIM_C - {1'b0, step_r};
    rot_d     = (work_q << step_r) | (work_q >> rsh);
    rem_d     = rem_q - step_r;
    accept    = in_valid && in_ready;
    // Only reachable when HV_DIM is not a power of two.
    shift_bad = {1'b0, shift_amt} >= DIM_C;
  end

`ifdef HV_UNBINDER_SIMILARITY_EN
  localparam int OVL_W = $clog2(HV_DIM+1);

  logic [HV_DIM-1:0] ref_q;
  logic [OVL_W-1:0]  overlap_q;
  logic [HV_DIM-1:0] pc_src;
  logic [OVL_W-1:0]  pc_val;

  function automatic logic [OVL_W-1:0] popcount(input logic [HV_DIM-1:0] v);
    logic [OVL_W-1:0] c;
    c = '0;
    for (int i = 0; i < HV_DIM; i++) begin
      c = c + OVL_W'(v[i]);
    end
    return c;
  endfunction

  // DONE is entered either straight from IDLE (zero shift, operands come
  // from the ports) or from the last ROTATE step (operands from registers),
  // so a single popcount serves both entry paths.
  always_comb begin
    pc_src = (state_q == IDLE) ? (bound_hv & ref_hv) : (rot_d & ref_q);
    pc_val = popcount(pc_src);
  end

  assign overlap = overlap_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef HV_UNBINDER_SIMILARITY_EN
      ref_q       <= '0;
      overlap_q   <= '0;
`endif
    end else if (en) begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (shift_bad) begin
              err_q <= 1'b1;
            end else begin
              work_q <= bound_hv;
              rem_q  <= shift_amt;
`ifdef HV_UNBINDER_SIMILARITY_EN
              ref_q  <= ref_hv;
`endif
              if (shift_amt == '0) begin
                state_q     <= DONE;
                out_valid_q <= 1'b1;
`ifdef HV_UNBINDER_SIMILARITY_EN
                overlap_q   <= pc_val;
`endif
              end else begin
                state_q <= ROTATE;
              end
            end
          end
        end
        ROTATE: begin
          work_q <= rot_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`ifdef HV_UNBINDER_SIMILARITY_EN
            overlap_q   <= pc_val;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_unbinder.sv
// Bench for hv_unbinder: three instances cover HV_DIM/STEP combinations
// 16/1 (index 0), 16/4 (index 1) and 12/1 (index 2).
module tb_hv_unbinder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_s;
  logic [2:0]  en_s;
  logic [2:0]  iv_s;
  logic [2:0]  ordy_s;
  logic [15:0] bhv_s [3];
  logic [3:0]  sa_s  [3];

  logic [2:0]  ir_w;
  logic [2:0]  ov_w;
  logic [2:0]  err_w;
  logic [15:0] unb_a;
  logic [15:0] unb_b;
  logic [11:0] unb_c;

  int checks = 0;
  int errors = 0;

  hv_unbinder #(.HV_DIM(16), .STEP(1)) u_a (
    .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .in_valid(iv_s[0]), .in_ready(ir_w[0]),
    .bound_hv(bhv_s[0]), .shift_amt(sa_s[0]), .out_valid(ov_w[0]), .out_ready(ordy_s[0]),
    .unbound_hv(unb_a), .err(err_w[0])
  );

  hv_unbinder #(.HV_DIM(16), .STEP(4)) u_b (
    .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .in_valid(iv_s[1]), .in_ready(ir_w[1]),
    .bound_hv(bhv_s[1]), .shift_amt(sa_s[1]), .out_valid(ov_w[1]), .out_ready(ordy_s[1]),
    .unbound_hv(unb_b), .err(err_w[1])
  );

  hv_unbinder #(.HV_DIM(12), .STEP(1)) u_c (
    .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .in_valid(iv_s[2]), .in_ready(ir_w[2]),
    .bound_hv(bhv_s[2][11:0]), .shift_amt(sa_s[2]), .out_valid(ov_w[2]), .out_ready(ordy_s[2]),
    .unbound_hv(unb_c), .err(err_w[2])
  );

  function automatic logic [15:0] get_unb(input int d);
    case (d)
      0:       return unb_a;
      1:       return unb_b;
      default: return {4'h0, unb_c};
    endcase
  endfunction

  // Reference model: cyclic rotations on a W-bit vector, by index arithmetic.
  function automatic logic [15:0] rotl(input logic [15:0] v, input int k, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[(i + k) % w] = v[i];
    return r;
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v, input int k, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[(i + k) % w];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, optional en stall, measure edges until
  // out_valid, hold under backpressure for bp cycles, then hand off.
  // Edges counted from the acceptance edge: ceil(k/S) edges, i.e. out_valid
  // in the (N+1)-th cycle after the acceptance cycle.
  task automatic run_op(input int d, input logic [15:0] v, input int k, input int s,
                        input int stall_at, input int stall_len, input int bp,
                        input logic [15:0] exp);
    int edges;
    bit seen;
    en_s[d]   = 1'b1;
    ordy_s[d] = 1'b0;
    iv_s[d]   = 1'b1;
    bhv_s[d]  = v;
    sa_s[d]   = 4'(k);
    #1;
    chk("in_ready_before_accept", 32'(ir_w[d]), 32'd1);
    step();
    iv_s[d]  = 1'b0;
    bhv_s[d] = ~v;
    sa_s[d]  = 4'($urandom);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 64) begin
      if (ov_w[d] === 1'b1) begin
        seen = 1'b1;
      end else begin
        en_s[d] = !(edges >= stall_at && edges < stall_at + stall_len);
        step();
        edges++;
      end
    end
    en_s[d] = 1'b1;
    #1;
    chk("out_valid_seen", 32'(seen), 32'd1);
    chk("latency_edges", edges, (k + s - 1) / s + stall_len);
    chk("unbound_value", 32'(get_unb(d)), 32'(exp));
    chk("in_ready_low_in_done", 32'(ir_w[d]), 32'd0);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("hold_valid", 32'(ov_w[d]), 32'd1);
      chk("hold_value", 32'(get_unb(d)), 32'(exp));
    end
    ordy_s[d] = 1'b1;
    step();
    ordy_s[d] = 1'b0;
    #1;
    chk("valid_after_handoff", 32'(ov_w[d]), 32'd0);
    chk("in_ready_after_handoff", 32'(ir_w[d]), 32'd1);
  endtask

  initial begin
    int seen_ov;
    logic [15:0] v;
    int k;

    rst_s  = 3'b111;
    en_s   = 3'b000;
    iv_s   = 3'b000;
    ordy_s = 3'b000;
    for (int d = 0; d < 3; d++) begin
      bhv_s[d] = '0;
      sa_s[d]  = '0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_out_valid", 32'(ov_w[d]), 32'd0);
      chk("reset_err", 32'(err_w[d]), 32'd0);
      chk("reset_unbound", 32'(get_unb(d)), 32'd0);
    end
    repeat (2) step();
    en_s  = 3'b111;
    rst_s = 3'b000;
    #1;
    chk("in_ready_after_reset", 32'(ir_w), 32'h7);

    // Rejection on the 12-bit instance: shift 13 is out of range.
    iv_s[2]  = 1'b1;
    bhv_s[2] = 16'h0FFF;
    sa_s[2]  = 4'd13;
    step();
    iv_s[2] = 1'b0;
    #1;
    chk("reject_err_pulse", 32'(err_w[2]), 32'd1);
    chk("reject_stays_idle", 32'(ir_w[2]), 32'd1);
    chk("reject_no_valid", 32'(ov_w[2]), 32'd0);
    step();
    chk("reject_err_cleared", 32'(err_w[2]), 32'd0);
    seen_ov = 0;
    repeat (4) begin
      step();
      if (ov_w[2] !== 1'b0) seen_ov++;
    end
    chk("reject_no_later_valid", seen_ov, 0);
    chk("reject_no_capture", 32'(get_unb(2)), 32'd0);

    // Directed vectors.
    run_op(0, 16'h0001, 3, 1, 0, 0, 0, 16'h0008);
    run_op(1, 16'h8001, 9, 4, 0, 0, 0, 16'h0300);
    run_op(0, 16'hA5A5, 0, 1, 0, 0, 5, 16'hA5A5);
    run_op(2, 16'h0001, 6, 1, 0, 0, 0, 16'h0040);
    run_op(2, 16'h0001, 6, 1, 2, 3, 0, 16'h0040);
    run_op(1, 16'h1234, 15, 4, 0, 0, 1, rotl(16'h1234, 15, 16));

    // en=0 in IDLE: no handshake, in_ready low.
    en_s[1] = 1'b0;
    iv_s[1] = 1'b1;
    sa_s[1] = 4'd5;
    #1;
    chk("en0_in_ready", 32'(ir_w[1]), 32'd0);
    repeat (2) step();
    iv_s[1] = 1'b0;
    en_s[1] = 1'b1;
    #1;
    chk("en0_no_accept", 32'(ir_w[1]), 32'd1);
    chk("en0_no_valid", 32'(ov_w[1]), 32'd0);

    // Randomized unbinding: bind by right rotation in the model, expect the
    // original back.
    for (int n = 0; n < 8; n++) begin
      v = 16'($urandom);
      k = $urandom_range(0, 15);
      run_op(1, rotr(v, k, 16), k, 4, 0, 0, $urandom_range(0, 3), v);
    end
    for (int n = 0; n < 6; n++) begin
      v = 16'($urandom) & 16'h0FFF;
      k = $urandom_range(0, 11);
      run_op(2, rotr(v, k, 12), k, 1, 0, 0, $urandom_range(0, 2), v);
    end

    // Reset mid-ROTATE discards the operation.
    iv_s[0]  = 1'b1;
    bhv_s[0] = 16'h00F0;
    sa_s[0]  = 4'd10;
    step();
    iv_s[0] = 1'b0;
    repeat (3) step();
    chk("midrot_no_valid", 32'(ov_w[0]), 32'd0);
    rst_s[0] = 1'b1;
    #1;
    chk("midrot_rst_valid", 32'(ov_w[0]), 32'd0);
    chk("midrot_rst_unbound", 32'(get_unb(0)), 32'd0);
    step();
    rst_s[0] = 1'b0;
    #1;
    chk("post_rst_in_ready_en1", 32'(ir_w[0]), 32'd1);
    en_s[0] = 1'b0;
    #1;
    chk("post_rst_in_ready_en0", 32'(ir_w[0]), 32'd0);
    en_s[0] = 1'b1;
    seen_ov = 0;
    repeat (15) begin
      step();
      if (ov_w[0] !== 1'b0) seen_ov++;
    end
    chk("post_rst_no_valid", seen_ov, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
